// File: rtl/centisecond_tick.sv
// Centisecond tick generator: start/stop/clear button FSM that drives a phase counter and tick strobe.
// Optional button debouncing is enabled by defining CENTISECOND_TICK_DEBOUNCE_EN.
module centisecond_tick #(
    parameter int DIV         = 10,
    parameter int HIGH_CYCLES = 5,
    parameter int DB_CYCLES   = 20
) (
    input  logic       i_clk_0_001s,
    input  logic       i_reset,
    input  logic [4:0] state,
    input  logic       is_modify,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic       i_clear,
    output logic       o_enable,
    output logic [3:0] o_ms,
    output logic       o_run,
    output logic       o_clear
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} fsm_t;

    localparam logic [3:0] MS_MAX = 4'(DIV - 1);
    localparam logic [3:0] MS_HI  = 4'(HIGH_CYCLES);

    // Button vector order: [2]=clear, [1]=stop, [0]=start
    logic [2:0] btn_raw;
    logic [2:0] btn;
    assign btn_raw = {i_clear, i_stop, i_start};

    // The field selector is part of the external interface but does not affect ticking
    logic unused_state;
    assign unused_state = ^state;

`ifdef CENTISECOND_TICK_DEBOUNCE_EN
    localparam int CW = $clog2(DB_CYCLES + 1);

    logic [2:0]         db_q;
    logic [2:0][CW-1:0] db_cnt_q;

    // Output flips only after DB_CYCLES consecutive samples that disagree with it
    always_ff @(posedge i_clk_0_001s) begin
        if (i_reset) begin
            db_q     <= '0;
            db_cnt_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (btn_raw[i] != db_q[i]) begin
                    if (db_cnt_q[i] == CW'(DB_CYCLES - 1)) begin
                        db_q[i]     <= btn_raw[i];
                        db_cnt_q[i] <= '0;
                    end else begin
                        db_cnt_q[i] <= db_cnt_q[i] + CW'(1);
                    end
                end else begin
                    db_cnt_q[i] <= '0;
                end
            end
        end
    end

    assign btn = db_q;
`else
    logic [31:0] unused_db;
    assign unused_db = DB_CYCLES;
    assign btn       = btn_raw;
`endif

    logic [2:0] prev_q;
    logic [2:0] ev_q;

    // Release detection; the registered flag is consumed on the following edge
    always_ff @(posedge i_clk_0_001s) begin
        if (i_reset) begin
            prev_q <= '0;
            ev_q   <= '0;
        end else begin
            prev_q <= btn;
            ev_q   <= prev_q & ~btn;
        end
    end

    fsm_t       fsm_q, fsm_d;
    logic [3:0] ms_q, ms_d;
    logic       en_q, en_d;
    logic       run_q, run_d;
    logic       clr_q, clr_d;

    always_ff @(posedge i_clk_0_001s) begin
        if (i_reset) begin
            fsm_q <= IDLE;
            ms_q  <= '0;
            en_q  <= 1'b0;
            run_q <= 1'b0;
            clr_q <= 1'b0;
        end else begin
            fsm_q <= fsm_d;
            ms_q  <= ms_d;
            en_q  <= en_d;
            run_q <= run_d;
            clr_q <= clr_d;
        end
    end

    always_comb begin
        fsm_d = fsm_q;
        ms_d  = ms_q;
        if (ev_q[2]) begin
            fsm_d = IDLE;
        end else if (is_modify) begin
            if (fsm_q == RUN) fsm_d = PAUSE;
        end else if (ev_q[1]) begin
            if (fsm_q == RUN) fsm_d = PAUSE;
        end else if (ev_q[0]) begin
            if (fsm_q == IDLE || fsm_q == PAUSE) fsm_d = RUN;
        end

        // Leaving IDLE shows phase 0 first; resuming from PAUSE advances immediately
        if (fsm_d == IDLE) begin
            ms_d = '0;
        end else if (fsm_d == RUN && fsm_q != IDLE) begin
            ms_d = (ms_q == MS_MAX) ? 4'd0 : ms_q + 4'd1;
        end

        en_d  = (fsm_d != IDLE) && (ms_d < MS_HI);
        run_d = (fsm_d == RUN);
        clr_d = ev_q[2];
    end

    assign o_ms     = ms_q;
    assign o_enable = en_q;
    assign o_run    = run_q;
    assign o_clear  = clr_q;

endmodule

// File: doc/centisecond_tick.md
CENTISECOND_TICK -- requirements
Module: centisecond_tick

Interface
REQ-001 Parameter DIV, default 10, meaning ms-clock cycles per centisecond tick period; legal range 2..15.
REQ-002 Parameter HIGH_CYCLES, default 5, meaning cycles per period with o_enable high; legal range 1..DIV-1.
REQ-003 Parameter DB_CYCLES, default 20, meaning debounce stability window in cycles; used only when the debounce macro is defined.
REQ-004 Port i_clk_0_001s, input, 1, 1 kHz system clock; all logic on rising edge.
REQ-005 Port i_reset, input, 1, reset; synchronous, active-high.
REQ-006 Port state, input, 5, current display/edit field selector.
REQ-007 Port is_modify, input, 1, edit mode active.
REQ-008 Port i_start, input, 1, start/resume button, level, active-high.
REQ-009 Port i_stop, input, 1, pause button, level, active-high.
REQ-010 Port i_clear, input, 1, clear button, level, active-high.
REQ-011 Port o_enable, output, 1, registered tick strobe; each falling edge marks one centisecond for the downstream counter's i_enable.
REQ-012 Port o_ms, output, 4, registered phase count 0..DIV-1 within the current tick period.
REQ-013 Port o_run, output, 1, registered; high only in RUN.
REQ-014 Port o_clear, output, 1, registered one-cycle pulse on clear.

Function
REQ-015 Each button SHALL yield a one-cycle event flag: register the previous sample; the flag is set on the edge where the previous sample is 1 and the current input is 0 (release), and is acted on at the following edge.
REQ-016 FSM states IDLE, RUN, PAUSE; reset state IDLE.
REQ-017 Event priority clear > stop > start; only the highest-priority event present in a cycle SHALL take effect.
REQ-018 Clear event from any state SHALL go to IDLE, set o_ms=0 and o_enable=0, and pulse o_clear high for exactly one cycle.
REQ-019 IDLE + start -> RUN; PAUSE + start -> RUN; RUN + stop -> PAUSE; all other start/stop combinations leave the state unchanged.
REQ-020 While is_modify==1, start events SHALL be ignored and RUN SHALL move to PAUSE on the next edge; clear remains honoured.
REQ-021 In RUN, o_ms SHALL increment by 1 per cycle and wrap from DIV-1 to 0; the first RUN cycle after IDLE has o_ms=0.
REQ-022 o_enable SHALL equal 1 exactly when the state is RUN or PAUSE and o_ms < HIGH_CYCLES, updated on the same edge as o_ms.
REQ-023 In RUN, o_enable SHALL produce exactly one falling edge per DIV cycles, on the edge where o_ms goes from HIGH_CYCLES-1 to HIGH_CYCLES.
REQ-024 In PAUSE, o_ms and o_enable SHALL hold; on resume, counting continues from the held o_ms, so no tick is lost or duplicated.
REQ-025 In IDLE, o_ms=0, o_enable=0, o_run=0.

Reset
REQ-026 When i_reset=1 at a rising edge: state=IDLE, o_enable=0, o_ms=0, o_run=0, o_clear=0, all edge/debounce registers=0.
REQ-027 Reset SHALL override all events in the same cycle; a reset mid-RUN or mid-pulse SHALL produce no o_clear pulse.

Configuration
REQ-028 Macro CENTISECOND_TICK_DEBOUNCE_EN: when defined, each button SHALL pass through a debouncer whose output changes only after the raw input has been stable for DB_CYCLES consecutive cycles, and REQ-015 SHALL act on the debounced signal; when undefined, REQ-015 SHALL act on the raw input and no debounce logic is present.

Verification
REQ-029 Reset, then pulse i_start 1 cycle -> o_run=1; o_ms follows 0,1,...,9,0; o_enable high while o_ms=0..4; falling edge every 10 cycles.
REQ-030 RUN, press stop at o_ms=3, wait 50 cycles, then press start -> o_ms holds 3 with o_enable=1 during PAUSE; resumes 4,5; next falling edge when o_ms goes 4->5.
REQ-031 Clear, stop and start released in the same cycle during RUN -> state IDLE, o_clear high exactly 1 cycle, o_ms=0, o_enable=0.
REQ-032 RUN, then set is_modify=1 -> PAUSE on the next edge; start ignored while is_modify=1; start after is_modify=0 -> RUN.
REQ-033 Assert i_reset at o_ms=2 in RUN -> next cycle all outputs 0, state IDLE, no o_clear pulse.
REQ-034 With CENTISECOND_TICK_DEBOUNCE_EN defined, a 5-cycle i_start glitch -> no transition; a 25-cycle press then release -> RUN.
